// File: rtl/ps_pkg.sv
// Shared definitions for the program-sequencer PC stack: sticky bit positions
// and the PS register-file addresses that expose the stack to software.
package ps_pkg;

    localparam int unsigned STK_EMPTY = 0;
    localparam int unsigned STK_FULL  = 1;
    localparam int unsigned STK_OVF   = 2;
    localparam int unsigned STK_UNF   = 3;

    localparam logic [4:0] PCSTCK = 5'b00100;
    localparam logic [4:0] PCSTKP = 5'b00101;
    localparam logic [4:0] STCKY  = 5'b11110;

endpackage

// File: rtl/ps_stck_ram.sv
// DEPTH x AW register array for the PC stack: one synchronous write port,
// one asynchronous read port, no reset on the storage.
module ps_stck_ram #(
    parameter int AW    = 16,
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  logic [AW-1:0] i_wdata,
    input  logic [IW-1:0] i_raddr,
    output logic [AW-1:0] o_rdata
);

    logic [AW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ps_pcstck_ctrl.sv
// Program-sequencer PC stack: call/return and explicit push/pop, ureg
// top-of-stack write, sticky overflow/underflow and fetch halt.
module ps_pcstck_ctrl
    import ps_pkg::*;
#(
    parameter  int AW    = 16,
    parameter  int DEPTH = 4,
    localparam int PTRW  = $clog2(DEPTH) + 1
) (
    input  logic            clk_rf,
    input  logic            rst,
    input  logic            ps_call,
    input  logic [AW-1:0]   ps_call_add,
    input  logic            ps_pshstck,
    input  logic [AW-1:0]   ps_psh_dt,
    input  logic            ps_rtrn,
    input  logic            ps_popstck,
    input  logic            ps_tos_wen,
    input  logic [AW-1:0]   ps_tos_wdt,
    input  logic            ps_clr_stcky,
    output logic [AW-1:0]   ps_tos,
    output logic [PTRW-1:0] ps_pcstck_pntr,
    output logic [3:0]      ps_stcky,
    output logic            ps_stck_err,
    output logic            ps_halt
);

    localparam int IW = $clog2(DEPTH);

    logic [PTRW-1:0] r_pntr;
    logic            r_ovf;
    logic            r_unf;
    logic            r_err;

    logic            w_psh;
    logic            w_pop;
    logic [AW-1:0]   w_data;
    logic            w_empty;
    logic            w_full;
    logic [PTRW-1:0] w_top_idx;
    logic [IW-1:0]   w_rd_idx;
    logic [AW-1:0]   w_rd_data;
    logic            w_we;
    logic [IW-1:0]   w_waddr;
    logic [AW-1:0]   w_wdata;
    logic [PTRW-1:0] w_nxt_pntr;
    logic            w_set_ovf;
    logic            w_set_unf;
    logic            w_err;

    assign w_psh     = ps_call | ps_pshstck;
    assign w_pop     = ps_rtrn | ps_popstck;
    assign w_data    = ps_call ? ps_call_add : ps_psh_dt;
    assign w_empty   = (r_pntr == '0);
    assign w_full    = (r_pntr == PTRW'(DEPTH));
    assign w_top_idx = r_pntr - PTRW'(1);
    // Empty stack reads slot 0 so the index stays in range for any DEPTH.
    assign w_rd_idx  = w_empty ? '0 : w_top_idx[IW-1:0];

    always_comb begin
        w_we       = 1'b0;
        w_waddr    = w_top_idx[IW-1:0];
        w_wdata    = w_data;
        w_nxt_pntr = r_pntr;
        w_set_ovf  = 1'b0;
        w_set_unf  = 1'b0;
        w_err      = 1'b0;
        if (w_psh && !w_pop) begin
            if (w_full) begin
                w_set_ovf = 1'b1;
                w_err     = 1'b1;
            end else begin
                w_we       = 1'b1;
                w_waddr    = r_pntr[IW-1:0];
                w_nxt_pntr = r_pntr + PTRW'(1);
            end
        end else if (w_pop && !w_psh) begin
            if (w_empty) begin
                w_set_unf = 1'b1;
                w_err     = 1'b1;
            end else begin
                w_nxt_pntr = w_top_idx;
            end
        end else if (w_psh && w_pop) begin
            // Simultaneous push/pop replaces the top; on an empty stack it is a plain push.
            w_we = 1'b1;
            if (w_empty) begin
                w_waddr    = r_pntr[IW-1:0];
                w_nxt_pntr = r_pntr + PTRW'(1);
            end
        end else if (ps_tos_wen) begin
            if (w_empty) begin
                w_err = 1'b1;
            end else begin
                w_we    = 1'b1;
                w_wdata = ps_tos_wdt;
            end
        end
    end

    always_ff @(posedge clk_rf) begin
        if (rst) begin
            r_pntr <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_pntr <= w_nxt_pntr;
            r_ovf  <= w_set_ovf | (r_ovf & ~ps_clr_stcky);
            r_unf  <= w_set_unf | (r_unf & ~ps_clr_stcky);
            r_err  <= w_err;
        end
    end

    ps_stck_ram #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_ram (
        .i_clk   (clk_rf),
        .i_we    (w_we & ~rst),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        ps_stcky            = '0;
        ps_stcky[STK_EMPTY] = w_empty;
        ps_stcky[STK_FULL]  = w_full;
        ps_stcky[STK_OVF]   = r_ovf;
        ps_stcky[STK_UNF]   = r_unf;
    end

    assign ps_tos         = w_empty ? '0 : w_rd_data;
    assign ps_pcstck_pntr = r_pntr;
    assign ps_stck_err    = r_err;
    assign ps_halt        = r_ovf;

endmodule

// File: tb/tb_ps_pcstck_ctrl.sv
// Bench for ps_pcstck_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based stack model.
module tb_ps_pcstck_ctrl;

    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int PTRW  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            call;
    logic [AW-1:0]   cadd;
    logic            pshstck;
    logic [AW-1:0]   pdt;
    logic            rtrn;
    logic            popstck;
    logic            tos_wen;
    logic [AW-1:0]   tos_wdt;
    logic            clr;
    logic [AW-1:0]   tos;
    logic [PTRW-1:0] pntr;
    logic [3:0]      stcky;
    logic            err;
    logic            halt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] m_q[$];
    bit            m_ovf;
    bit            m_unf;
    bit            m_err;

    always #5 clk = ~clk;

    ps_pcstck_ctrl #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk_rf         (clk),
        .rst            (rst),
        .ps_call        (call),
        .ps_call_add    (cadd),
        .ps_pshstck     (pshstck),
        .ps_psh_dt      (pdt),
        .ps_rtrn        (rtrn),
        .ps_popstck     (popstck),
        .ps_tos_wen     (tos_wen),
        .ps_tos_wdt     (tos_wdt),
        .ps_clr_stcky   (clr),
        .ps_tos         (tos),
        .ps_pcstck_pntr (pntr),
        .ps_stcky       (stcky),
        .ps_stck_err    (err),
        .ps_halt        (halt)
    );

    task automatic idle_inputs();
        rst = 1'b0; call = 1'b0; cadd = '0; pshstck = 1'b0; pdt = '0;
        rtrn = 1'b0; popstck = 1'b0; tos_wen = 1'b0; tos_wdt = '0; clr = 1'b0;
    endtask

    // Stack semantics expressed on a queue: back of the queue is the top entry.
    function automatic void model_update();
        bit            p, o, so, su;
        logic [AW-1:0] d;
        p = call | pshstck;
        o = rtrn | popstck;
        d = call ? cadd : pdt;
        so = 0; su = 0; m_err = 0;
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_unf = 0;
            return;
        end
        if (p && !o) begin
            if (m_q.size() == DEPTH) begin so = 1; m_err = 1; end
            else m_q.push_back(d);
        end else if (o && !p) begin
            if (m_q.size() == 0) begin su = 1; m_err = 1; end
            else void'(m_q.pop_back());
        end else if (p && o) begin
            if (m_q.size() == 0) m_q.push_back(d);
            else m_q[m_q.size()-1] = d;
        end else if (tos_wen) begin
            if (m_q.size() == 0) m_err = 1;
            else m_q[m_q.size()-1] = tos_wdt;
        end
        m_ovf = so | (m_ovf & !clr);
        m_unf = su | (m_unf & !clr);
    endfunction

    function automatic logic [AW-1:0] exp_tos();
        return (m_q.size() == 0) ? '0 : m_q[m_q.size()-1];
    endfunction

    function automatic logic [3:0] exp_stcky();
        return {m_unf, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_tests += 5;
        if (pntr !== 3'd0) begin n_fail++; $display("FAIL reset_pntr: got %0d expected 0", pntr); end
        if (stcky !== 4'b0001) begin n_fail++; $display("FAIL reset_stcky: got %b expected 0001", stcky); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b expected 0", halt); end
        if (tos !== 16'h0000) begin n_fail++; $display("FAIL reset_tos: got %h expected 0000", tos); end
    endtask

    task automatic test_call_return();
        logic [AW-1:0] exp_r [4];
        for (int i = 0; i < 4; i++) begin
            call = 1'b1; cadd = AW'((i + 1) * 16);
            tick();
        end
        n_tests += 3;
        if (pntr !== 3'd4) begin n_fail++; $display("FAIL call4_pntr: got %0d expected 4", pntr); end
        if (tos !== 16'h0040) begin n_fail++; $display("FAIL call4_tos: got %h expected 0040", tos); end
        if (stcky !== 4'b0010) begin n_fail++; $display("FAIL call4_stcky: got %b expected 0010", stcky); end
        exp_r[0] = 16'h0030; exp_r[1] = 16'h0020; exp_r[2] = 16'h0010; exp_r[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            rtrn = 1'b1;
            tick();
            n_tests++;
            if (tos !== exp_r[i]) begin n_fail++; $display("FAIL rtrn%0d_tos: got %h expected %h", i, tos, exp_r[i]); end
        end
        n_tests++;
        if (stcky !== 4'b0001) begin n_fail++; $display("FAIL rtrn_stcky: got %b expected 0001", stcky); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            call = 1'b1; cadd = AW'((i + 1) * 16);
            tick();
        end
        pshstck = 1'b1; pdt = 16'hBEEF;
        tick();
        n_tests += 4;
        if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", err); end
        if (stcky !== 4'b0110) begin n_fail++; $display("FAIL ovf_stcky: got %b expected 0110", stcky); end
        if (halt !== 1'b1) begin n_fail++; $display("FAIL ovf_halt: got %b expected 1", halt); end
        if (tos !== 16'h0040) begin n_fail++; $display("FAIL ovf_tos: got %h expected 0040", tos); end
        tick();
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_pulse: got %b expected 0", err); end
        clr = 1'b1;
        tick();
        n_tests += 2;
        if (stcky !== 4'b0010) begin n_fail++; $display("FAIL ovf_clr_stcky: got %b expected 0010", stcky); end
        if (halt !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_halt: got %b expected 0", halt); end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 4; i++) begin
            rtrn = 1'b1;
            tick();
        end
        popstck = 1'b1;
        tick();
        n_tests += 3;
        if (err !== 1'b1) begin n_fail++; $display("FAIL unf_err: got %b expected 1", err); end
        if (stcky !== 4'b1001) begin n_fail++; $display("FAIL unf_stcky: got %b expected 1001", stcky); end
        if (pntr !== 3'd0) begin n_fail++; $display("FAIL unf_pntr: got %0d expected 0", pntr); end
        popstck = 1'b1; clr = 1'b1;
        tick();
        n_tests += 2;
        if (stcky !== 4'b1001) begin n_fail++; $display("FAIL unf_set_wins: got %b expected 1001", stcky); end
        if (err !== 1'b1) begin n_fail++; $display("FAIL unf_err2: got %b expected 1", err); end
        clr = 1'b1;
        tick();
        n_tests++;
        if (stcky !== 4'b0001) begin n_fail++; $display("FAIL unf_clr: got %b expected 0001", stcky); end
    endtask

    task automatic test_replace();
        pshstck = 1'b1; pdt = 16'h0010;
        tick();
        pshstck = 1'b1; pdt = 16'h0020;
        tick();
        n_tests += 2;
        if (pntr !== 3'd2) begin n_fail++; $display("FAIL repl_pre_pntr: got %0d expected 2", pntr); end
        if (tos !== 16'h0020) begin n_fail++; $display("FAIL repl_pre_tos: got %h expected 0020", tos); end
        call = 1'b1; cadd = 16'h0055; rtrn = 1'b1;
        tick();
        n_tests += 3;
        if (pntr !== 3'd2) begin n_fail++; $display("FAIL repl_pntr: got %0d expected 2", pntr); end
        if (tos !== 16'h0055) begin n_fail++; $display("FAIL repl_tos: got %h expected 0055", tos); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL repl_err: got %b expected 0", err); end
    endtask

    task automatic test_tos_write();
        rtrn = 1'b1;
        tick();
        tos_wen = 1'b1; tos_wdt = 16'h1234;
        tick();
        n_tests += 2;
        if (tos !== 16'h1234) begin n_fail++; $display("FAIL tosw_tos: got %h expected 1234", tos); end
        if (pntr !== 3'd1) begin n_fail++; $display("FAIL tosw_pntr: got %0d expected 1", pntr); end
        tos_wen = 1'b1; tos_wdt = 16'h1234; pshstck = 1'b1; pdt = 16'h0099;
        tick();
        n_tests += 2;
        if (tos !== 16'h0099) begin n_fail++; $display("FAIL tosw_psh_tos: got %h expected 0099", tos); end
        if (pntr !== 3'd2) begin n_fail++; $display("FAIL tosw_psh_pntr: got %0d expected 2", pntr); end
        popstck = 1'b1;
        tick();
        n_tests++;
        if (tos !== 16'h1234) begin n_fail++; $display("FAIL tosw_below: got %h expected 1234", tos); end
        popstck = 1'b1;
        tick();
        tos_wen = 1'b1; tos_wdt = 16'hAAAA;
        tick();
        n_tests += 3;
        if (err !== 1'b1) begin n_fail++; $display("FAIL tosw_empty_err: got %b expected 1", err); end
        if (stcky !== 4'b0001) begin n_fail++; $display("FAIL tosw_empty_stcky: got %b expected 0001", stcky); end
        if (tos !== 16'h0000) begin n_fail++; $display("FAIL tosw_empty_tos: got %h expected 0000", tos); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            call = 1'b1; cadd = AW'(16'h0100 + i);
            tick();
        end
        rtrn = 1'b1;
        tick();
        n_tests += 2;
        if (pntr !== 3'd3) begin n_fail++; $display("FAIL rmid_pre_pntr: got %0d expected 3", pntr); end
        if (halt !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_halt: got %b expected 1", halt); end
        rst = 1'b1; pshstck = 1'b1; pdt = 16'h7777;
        tick();
        n_tests += 5;
        if (pntr !== 3'd0) begin n_fail++; $display("FAIL rmid_pntr: got %0d expected 0", pntr); end
        if (stcky !== 4'b0001) begin n_fail++; $display("FAIL rmid_stcky: got %b expected 0001", stcky); end
        if (halt !== 1'b0) begin n_fail++; $display("FAIL rmid_halt: got %b expected 0", halt); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b expected 0", err); end
        if (tos !== 16'h0000) begin n_fail++; $display("FAIL rmid_tos: got %h expected 0000", tos); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst     = ($urandom_range(0, 79) == 0);
            call    = ($urandom_range(0, 3) == 0);
            cadd    = AW'($urandom);
            pshstck = ($urandom_range(0, 4) == 0);
            pdt     = AW'($urandom);
            rtrn    = ($urandom_range(0, 2) == 0);
            popstck = ($urandom_range(0, 4) == 0);
            tos_wen = ($urandom_range(0, 3) == 0);
            tos_wdt = AW'($urandom);
            clr     = ($urandom_range(0, 9) == 0);
            tick();
            n_tests += 5;
            if (tos !== exp_tos()) begin n_fail++; $display("FAIL rnd%0d_tos: got %h expected %h", c, tos, exp_tos()); end
            if (pntr !== PTRW'(m_q.size())) begin n_fail++; $display("FAIL rnd%0d_pntr: got %0d expected %0d", c, pntr, m_q.size()); end
            if (stcky !== exp_stcky()) begin n_fail++; $display("FAIL rnd%0d_stcky: got %b expected %b", c, stcky, exp_stcky()); end
            if (err !== m_err) begin n_fail++; $display("FAIL rnd%0d_err: got %b expected %b", c, err, m_err); end
            if (halt !== m_ovf) begin n_fail++; $display("FAIL rnd%0d_halt: got %b expected %b", c, halt, m_ovf); end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_call_return();
        test_overflow();
        test_underflow();
        test_replace();
        test_tos_write();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps_pcstck_ctrl.md
Name: ps_pcstck_ctrl

Overview:
- Parametrised program-sequencer PC stack: the next-generation replacement for the single-entry PC stack and its sticky logic in the sequencer.
- Holds return addresses for call/return and explicit push/pop, with a configurable depth and address width.
- Supports a direct top-of-stack write from the ureg path, separate underflow and overflow stickies, a software sticky-clear and a fetch-halt output.
- Sits in the sequencer's register-file stage, clocked by clk_rf.

Parameters:
- AW, 16, address/data width of each stack entry.
- DEPTH, 4, number of entries (>=2).
- PTRW, $clog2(DEPTH)+1, derived localparam; pointer width, counts 0..DEPTH.

Ports:
- clk_rf  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- ps_call  in  1  call: push ps_call_add.
- ps_call_add  in  AW  return address pushed on call.
- ps_pshstck  in  1  explicit push of ps_psh_dt.
- ps_psh_dt  in  AW  data for explicit push.
- ps_rtrn  in  1  return: pop.
- ps_popstck  in  1  explicit pop.
- ps_tos_wen  in  1  ureg write to the top-of-stack entry.
- ps_tos_wdt  in  AW  top-of-stack write data.
- ps_clr_stcky  in  1  clears the overflow and underflow stickies.
- ps_tos  out  AW  current top entry; 0 when empty.
- ps_pcstck_pntr  out  PTRW  entry count.
- ps_stcky  out  4  {underflow, overflow, full, empty}.
- ps_stck_err  out  1  one-cycle pulse on any rejected operation.
- ps_halt  out  1  equals the overflow sticky; stalls fetch.

Behaviour:
- Reset (rst=1 at an edge): pointer=0, ps_stcky=4'b0001, ps_stck_err=0, ps_halt=0, ps_tos=0. Storage contents are don't-care. Reset mid-operation discards that cycle's operation.
- Effective operations in a cycle:
  - psh = ps_call | ps_pshstck; data is ps_call_add if ps_call, else ps_psh_dt.
  - pop = ps_rtrn | ps_popstck.
- Push only, not full: mem[pntr] <= data; pntr+1.
- Push only, full: no write; overflow sticky set; ps_stck_err pulses.
- Pop only, not empty: pntr-1.
- Pop only, empty: pointer unchanged; underflow sticky set; err pulses.
- Push and pop together:
  - Not empty: replace top, mem[pntr-1] <= data; pointer unchanged; no error.
  - Empty: treated as push only.
- ps_tos_wen:
  - Honoured only when there is no psh and no pop that cycle, and the stack is not empty: mem[pntr-1] <= ps_tos_wdt.
  - When empty: ignored, err pulses, underflow is not set.
  - When a push or pop is present: ignored silently.
- empty/full are derived from the registered pointer (pntr==0 / pntr==DEPTH) and are never sticky.
- Overflow and underflow are sticky until rst or ps_clr_stcky.
  - If ps_clr_stcky coincides with a new error, the set wins.
- While overflow=1, the stack keeps operating normally; ps_halt=1.
- ps_tos, ps_stcky, ps_pcstck_pntr and ps_halt are combinational from registered state only. Any operation is therefore visible on the outputs the cycle after its edge (latency 1).
- The pointer never wraps: saturates at 0 and DEPTH.

Decomposition:
- Shared package ps_pkg:
  - sticky bit indices STK_EMPTY=0, STK_FULL=1, STK_OVF=2, STK_UNF=3.
  - PS register addresses: PCSTCK=5'b00100, PCSTKP=5'b00101, STCKY=5'b11110.
- Sub-module ps_stck_ram: DEPTH x AW register array with one write port (addr, data, en) and one asynchronous read port. Holds no reset.
- Control, pointer and sticky logic stay in ps_pcstck_ctrl.

Test Plan (AW=16, DEPTH=4):
- Reset, then 4 calls with 0x0010, 0x0020, 0x0030, 0x0040:
  - pntr=4, tos=0x0040, stcky=4'b0010 after the 4th.
  - Returns then give tos 0x0030, 0x0020, 0x0010, 0x0000; stcky ends 4'b0001.
- Full stack + ps_pshstck with 0xBEEF:
  - err pulses 1 cycle; stcky=4'b0110; halt=1; tos stays 0x0040.
  - ps_clr_stcky -> stcky=4'b0010, halt=0.
- Empty stack + ps_popstck:
  - err pulse; stcky=4'b1001; pntr=0.
  - Same cycle as ps_clr_stcky with a second pop: underflow remains 1.
- pntr=2, tos=0x0020; ps_call(0x0055) with ps_rtrn:
  - pntr=2, tos=0x0055, no err.
- pntr=1; ps_tos_wen with 0x1234:
  - tos=0x1234.
  - Repeated with ps_pshstck(0x0099) active: tos=0x0099, pntr=2, 0x1234 not written.
- Mid-sequence (pntr=3, overflow set), assert rst for one cycle alongside a push:
  - Next cycle pntr=0, stcky=4'b0001, halt=0, err=0.
